// File: rtl/gpu_types.sv
// gpu_types: shared GPU request/release types for the barrier path
package gpu_types;
    localparam int GPU_NUM_WARPS    = 4;
    localparam int GPU_NUM_BARRIERS = 4;
    localparam int GPU_NW_BITS      = $clog2(GPU_NUM_WARPS);
    localparam int GPU_NB_BITS      = $clog2(GPU_NUM_BARRIERS);

    typedef struct packed {
        logic                   valid;
        logic [GPU_NB_BITS-1:0] id;
        logic [GPU_NW_BITS-1:0] size_m1;
    } gpu_barrier_t;

    typedef struct packed {
        logic                     valid;
        logic [GPU_NB_BITS-1:0]   id;
        logic [GPU_NUM_WARPS-1:0] wmask;
    } gpu_barrier_rel_t;
endpackage

`define GPU_BARRIER_REL_BITS (1 + gpu_types::GPU_NB_BITS + gpu_types::GPU_NUM_WARPS)

// File: rtl/vx_barrier_entry.sv
// vx_barrier_entry: one barrier slot holding its arrival count and arrived-warp mask
module vx_barrier_entry #(
    parameter int NUM_WARPS = 4,
    localparam int NW_BITS = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_arrive,
    input  logic                 i_clear,
    input  logic [NW_BITS-1:0]   i_wid,
    input  logic [NW_BITS-1:0]   i_size_m1,
    output logic                 o_complete,
    output logic [NUM_WARPS-1:0] o_wmask
);
    logic [NW_BITS-1:0]   r_count;
    logic [NUM_WARPS-1:0] r_wmask;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
            r_wmask <= '0;
        end else if (i_arrive) begin
            r_count <= r_count + NW_BITS'(1);
            r_wmask <= r_wmask | (NUM_WARPS'(1) << i_wid);
        end
    end

    assign o_complete = r_count == i_size_m1;
    assign o_wmask    = r_wmask;
endmodule

// File: rtl/vx_barrier_ctrl.sv
// vx_barrier_ctrl: collects warp arrivals per barrier slot, stalls them, and
// issues one registered release to the scheduler when a barrier fills.
module vx_barrier_ctrl import gpu_types::*; #(
    parameter int NUM_WARPS    = GPU_NUM_WARPS,
    parameter int NUM_BARRIERS = GPU_NUM_BARRIERS,
    localparam int NW_BITS = $clog2(NUM_WARPS),
    localparam int NB_BITS = $clog2(NUM_BARRIERS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 barrier_valid,
    input  logic [NB_BITS-1:0]   barrier_id,
    input  logic [NW_BITS-1:0]   barrier_size_m1,
    input  logic [NW_BITS-1:0]   barrier_wid,
    output logic                 barrier_ready,
    output logic [NUM_WARPS-1:0] stall_mask,
    output logic                 release_valid,
    output logic [NB_BITS-1:0]   release_id,
    output logic [NUM_WARPS-1:0] release_mask,
    input  logic                 release_ready
);
    gpu_barrier_t         w_req;
    gpu_barrier_rel_t     r_rel;
    logic [NUM_WARPS-1:0] w_wmask [NUM_BARRIERS];
    logic [NUM_BARRIERS-1:0] w_complete;
    logic [NUM_WARPS-1:0] w_bit;
    logic [NUM_WARPS-1:0] r_stall;
    logic w_fire, w_hs, w_dup, w_acc, w_done;

    assign w_req         = '{valid: barrier_valid, id: barrier_id, size_m1: barrier_size_m1};
    assign barrier_ready = !r_rel.valid || release_ready;
    assign w_hs          = r_rel.valid && release_ready;
    assign w_fire        = w_req.valid && barrier_ready;
    assign w_bit         = NUM_WARPS'(1) << barrier_wid;
    assign w_dup         = |(w_wmask[w_req.id] & w_bit);
    assign w_acc         = w_fire && !w_dup;
    assign w_done        = w_acc && w_complete[w_req.id];

    for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_slot
        vx_barrier_entry #(.NUM_WARPS(NUM_WARPS)) u_entry (
            .clk        (clk),
            .reset      (reset),
            .i_arrive   (w_acc && !w_complete[b] && w_req.id == NB_BITS'(b)),
            .i_clear    (w_done && w_req.id == NB_BITS'(b)),
            .i_wid      (barrier_wid),
            .i_size_m1  (w_req.size_m1),
            .o_complete (w_complete[b]),
            .o_wmask    (w_wmask[b])
        );
    end

    // Release registers reload when a new completion coincides with a handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall <= '0;
            r_rel   <= '0;
        end else begin
            r_stall <= (r_stall & ~(w_hs ? r_rel.wmask : '0)) | (w_acc ? w_bit : '0);
            if (w_done)
                r_rel <= '{valid: 1'b1, id: w_req.id, wmask: w_wmask[w_req.id] | w_bit};
            else if (w_hs)
                r_rel.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk)
        if (!reset && w_fire)
            assert (!w_dup) else $warning("vx_barrier_ctrl: warp %0d arrived twice at barrier %0d", barrier_wid, barrier_id);

    assign stall_mask    = r_stall;
    assign release_valid = r_rel.valid;
    assign release_id    = r_rel.id;
    assign release_mask  = r_rel.wmask;
endmodule

// File: tb/tb_vx_barrier_ctrl.sv
// tb_vx_barrier_ctrl: table-driven arrival vectors with a scoreboard of expected registered outputs
module tb_vx_barrier_ctrl;
    logic       clk = 0;
    logic       reset;
    logic       barrier_valid;
    logic [1:0] barrier_id, barrier_size_m1, barrier_wid;
    logic       barrier_ready;
    logic [3:0] stall_mask;
    logic       release_valid;
    logic [1:0] release_id;
    logic [3:0] release_mask;
    logic       release_ready;

    vx_barrier_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .barrier_valid   (barrier_valid),
        .barrier_id      (barrier_id),
        .barrier_size_m1 (barrier_size_m1),
        .barrier_wid     (barrier_wid),
        .barrier_ready   (barrier_ready),
        .stall_mask      (stall_mask),
        .release_valid   (release_valid),
        .release_id      (release_id),
        .release_mask    (release_mask),
        .release_ready   (release_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] id, sz, wid;
        logic       rr, br;
        logic [3:0] stall;
        logic       rv;
        logic [1:0] rid;
        logic [3:0] rmask;
    } vec_t;

    typedef struct {
        logic [3:0] stall;
        logic       rv;
        logic [1:0] rid;
        logic [3:0] rmask;
    } exp_t;

    vec_t tab_a[$], tab_b[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   row     = 0;

    function automatic vec_t mk(input logic v, input logic [1:0] id, sz, wid, input logic rr, br,
                                input logic [3:0] st, input logic rv, input logic [1:0] rid, input logic [3:0] rm);
        mk = '{v, id, sz, wid, rr, br, st, rv, rid, rm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        exp_t e;
        @(negedge clk);
        barrier_valid = t.v; barrier_id = t.id; barrier_size_m1 = t.sz;
        barrier_wid = t.wid; release_ready = t.rr;
        #1 check($sformatf("row%0d barrier_ready", row), barrier_ready, t.br);
        sb.push_back('{t.stall, t.rv, t.rid, t.rmask});
        @(posedge clk);
        #1 e = sb.pop_front();
        check($sformatf("row%0d stall_mask", row), stall_mask, e.stall);
        check($sformatf("row%0d release_valid", row), release_valid, e.rv);
        if (e.rv) begin
            check($sformatf("row%0d release_id", row), release_id, e.rid);
            check($sformatf("row%0d release_mask", row), release_mask, e.rmask);
        end
        row++;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " stall_mask"}, stall_mask, 4'b0000);
        check({tag, " release_valid"}, release_valid, 1'b0);
        check({tag, " release_id"}, release_id, 2'd0);
        check({tag, " release_mask"}, release_mask, 4'b0000);
        check({tag, " barrier_ready"}, barrier_ready, 1'b1);
    endtask

    initial begin
        //                v  id sz wid rr br stall   rv rid rmask
        // barrier 1, four warps
        tab_a.push_back(mk(1, 1, 3, 0, 1, 1, 4'b0001, 0, 0, 4'b0000));
        tab_a.push_back(mk(1, 1, 3, 2, 1, 1, 4'b0101, 0, 0, 4'b0000));
        tab_a.push_back(mk(1, 1, 3, 1, 1, 1, 4'b0111, 0, 0, 4'b0000));
        tab_a.push_back(mk(1, 1, 3, 3, 1, 1, 4'b1111, 1, 1, 4'b1111));
        tab_a.push_back(mk(0, 0, 0, 0, 1, 1, 4'b0000, 0, 0, 4'b0000));
        // single-warp barrier
        tab_a.push_back(mk(1, 0, 0, 2, 1, 1, 4'b0100, 1, 0, 4'b0100));
        tab_a.push_back(mk(0, 0, 0, 0, 1, 1, 4'b0000, 0, 0, 4'b0000));
        // release back-pressure for five cycles with a pending arrival
        tab_a.push_back(mk(1, 2, 0, 1, 0, 1, 4'b0010, 1, 2, 4'b0010));
        for (int i = 0; i < 5; i++)
            tab_a.push_back(mk(1, 3, 0, 3, 0, 0, 4'b0010, 1, 2, 4'b0010));
        tab_a.push_back(mk(1, 3, 0, 3, 1, 1, 4'b1000, 1, 3, 4'b1000));
        tab_a.push_back(mk(0, 0, 0, 0, 1, 1, 4'b0000, 0, 0, 4'b0000));
        // interleaved barriers 0 and 2; completion reloads during a handshake
        tab_a.push_back(mk(1, 0, 1, 0, 1, 1, 4'b0001, 0, 0, 4'b0000));
        tab_a.push_back(mk(1, 2, 2, 1, 1, 1, 4'b0011, 0, 0, 4'b0000));
        tab_a.push_back(mk(1, 2, 2, 2, 1, 1, 4'b0111, 0, 0, 4'b0000));
        tab_a.push_back(mk(1, 0, 1, 3, 1, 1, 4'b1111, 1, 0, 4'b1001));
        tab_a.push_back(mk(1, 2, 2, 0, 1, 1, 4'b0111, 1, 2, 4'b0111));
        tab_a.push_back(mk(0, 0, 0, 0, 1, 1, 4'b0000, 0, 0, 4'b0000));
        // double arrival at barrier 3 is dropped
        tab_a.push_back(mk(1, 3, 1, 1, 1, 1, 4'b0010, 0, 0, 4'b0000));
        tab_a.push_back(mk(1, 3, 1, 1, 1, 1, 4'b0010, 0, 0, 4'b0000));
        tab_a.push_back(mk(1, 3, 1, 0, 1, 1, 4'b0011, 1, 3, 4'b0011));
        // non-completing arrival during a handshake drops release_valid
        tab_a.push_back(mk(1, 1, 1, 2, 1, 1, 4'b0100, 0, 0, 4'b0000));
        tab_a.push_back(mk(1, 1, 1, 3, 1, 1, 4'b1100, 1, 1, 4'b1100));
        tab_a.push_back(mk(0, 0, 0, 0, 1, 1, 4'b0000, 0, 0, 4'b0000));
        // two warps waiting at barrier 0 plus a pending release, before reset
        tab_a.push_back(mk(1, 0, 2, 0, 0, 1, 4'b0001, 0, 0, 4'b0000));
        tab_a.push_back(mk(1, 0, 2, 1, 0, 1, 4'b0011, 0, 0, 4'b0000));
        tab_a.push_back(mk(1, 1, 0, 2, 0, 1, 4'b0111, 1, 1, 4'b0100));
        // after reset a size_m1=1 barrier needs two fresh arrivals
        tab_b.push_back(mk(1, 0, 1, 3, 1, 1, 4'b1000, 0, 0, 4'b0000));
        tab_b.push_back(mk(1, 0, 1, 1, 1, 1, 4'b1010, 1, 0, 4'b1010));
        tab_b.push_back(mk(0, 0, 0, 0, 1, 1, 4'b0000, 0, 0, 4'b0000));

        reset = 1; barrier_valid = 0; barrier_id = 0; barrier_size_m1 = 0;
        barrier_wid = 0; release_ready = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        #1 check_idle("reset");

        foreach (tab_a[i]) apply(tab_a[i]);

        @(negedge clk);
        reset = 1; barrier_valid = 0; release_ready = 0;
        @(posedge clk);
        #1 check_idle("midreset");
        @(negedge clk);
        reset = 0;

        foreach (tab_b[i]) apply(tab_b[i]);

        check("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vx_barrier_ctrl.md
# vx_barrier_ctrl

Warp-scheduler-side consumer of the GPU unit's barrier requests (gpu_barrier_t). It tracks, per hardware barrier, how many warps have arrived and which ones. It holds arriving warps stalled until the last expected warp arrives, then issues a single release to the scheduler. It sits between the GPU execute unit and the warp scheduler, alongside the TMC, wspawn and split consumers.

## Interface
Clock is `clk`; reset is `reset`, synchronous and active-high.

Parameters:
- NUM_WARPS, default 4: number of hardware warps; NW_BITS = clog2(NUM_WARPS).
- NUM_BARRIERS, default 4: number of barrier slots; NB_BITS = clog2(NUM_BARRIERS).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- barrier_valid  in  1  arrival request from the GPU unit
- barrier_id  in  NB_BITS  barrier slot
- barrier_size_m1  in  NW_BITS  number of participating warps minus 1
- barrier_wid  in  NW_BITS  arriving warp
- barrier_ready  out  1  arrival accepted when valid && ready
- stall_mask  out  NUM_WARPS  warps currently held at any barrier
- release_valid  out  1  a barrier has completed
- release_id  out  NB_BITS  completed barrier
- release_mask  out  NUM_WARPS  warps to un-stall
- release_ready  in  1  scheduler accepts the release

## Operation
Per-slot state:
- count[NW_BITS]: arrivals so far.
- wmask[NUM_WARPS]: the arrived warps.

On an accepted arrival at slot b with warp w:
- If count[b] == barrier_size_m1, the barrier completes:
  - Load release_valid=1, release_id=b, release_mask=wmask[b] | (1<<w).
  - Clear count[b]=0 and wmask[b]=0, so the slot is immediately reusable.
- Otherwise, count[b]++ and wmask[b] |= (1<<w).
- In both cases, stall_mask |= (1<<w).

Completion is always decided against the size_m1 carried by the current request. Mismatched sizes across arrivals are not checked.

Edge cases:
- barrier_size_m1 == 0: immediate completion. release_mask is exactly (1<<w), and w is stalled only until the release handshake.
- Warp w already set in wmask[b] (double arrival): protocol error. The request is accepted and dropped with no state change, and a simulation-only assertion fires.
- Arrivals at different slots are independent. At most one arrival is accepted per cycle.

Handshake rules:
- barrier_ready = !release_valid || release_ready, and is combinational.
- release_valid/id/mask are held stable until release_valid && release_ready.
- On that handshake, stall_mask &= ~release_mask. The stall is lifted only at the handshake, not at completion.

Simultaneous release handshake and new arrival in the same cycle:
- stall_mask_next = (stall_mask & ~release_mask) | (1<<w).
- If the new arrival completes a barrier, the release registers reload with the new release. Otherwise release_valid drops to 0.

## Timing
- All outputs except barrier_ready are registered.
- Reset values: count=0, wmask=0 for every slot; stall_mask=0; release_valid=0, release_id=0, release_mask=0. barrier_ready=1 the first cycle after reset.
- Accepted arrival in cycle N: stall_mask shows the warp in N+1.
- Completing arrival in cycle N: release_valid=1 in N+1.
- Release handshake in cycle M: the warps leave stall_mask in M+1.
- Back-to-back arrivals are sustained at 1 per cycle while no release is pending or release_ready is held high.
- Reset mid-operation: all slots, stall_mask and any pending release are discarded in one cycle. No release is emitted.

## Structure
- Add to package gpu_types: gpu_barrier_rel_t {valid, id[NB_BITS], wmask[NUM_WARPS]} and `GPU_BARRIER_REL_BITS. The top packs the release outputs through it.
- The input side uses the existing gpu_barrier_t plus barrier_wid.
- One sub-module: vx_barrier_entry, instantiated NUM_BARRIERS times. Each instance holds count/wmask with arrive/clear inputs and a "complete" output.
- The top handles slot decode, release registers, stall_mask and the handshake.

## Test plan
- Barrier 1, size_m1=3: warps 0,2,1,3 arrive on consecutive cycles with release_ready=1. Required: stall_mask goes 0001 → 0101 → 0111. release_valid=1 with id=1 and mask=1111 in the cycle after warp 3 arrives. stall_mask=0000 one cycle after the handshake.
- size_m1=0, warp 2, barrier 0: release_valid next cycle with mask=0100. stall_mask bit 2 is set for exactly one cycle.
- release_ready held low for 5 cycles after a completion: barrier_ready=0 throughout and release outputs remain stable. A pending arrival is accepted in the handshake cycle, and stall_mask reflects both the cleared and the new bit.
- Interleaved barriers 0 (size_m1=1) and 2 (size_m1=2) with warps 0..3: two independent releases with correct ids and masks, and no cross-contamination of counts.
- Warp 1 arrives twice at barrier 3 (size_m1=1): the second arrival is dropped, count stays 1, and the assertion fires. Warp 0 then completes the barrier with mask=0011.
- Reset asserted with two warps waiting and a release pending: all outputs zero next cycle, barrier_ready=1, and a subsequent size_m1=1 barrier needs two fresh arrivals.
